// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU load/store vs. VGA frame reads, with a
// starvation bound in RUN and VGA-only access after halt. Optional macro: ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stop,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_stall,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_gnt,
    output logic              o_vga_rvalid,
    output logic [DATA_W-1:0] o_vga_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_halted
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       o_stat_cpu_gnt,
    output logic [15:0]       o_stat_vga_gnt,
    output logic [15:0]       o_stat_cpu_stall
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_starve_cnt;
    logic [7:0]        w_starve_next;
    logic              w_cpu_grant;
    logic              w_vga_grant;
    logic              w_cpu_stall;
    logic              r_cpu_rd;
    logic              r_vga_rd;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vga_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The stop cycle itself is still arbitrated with RUN rules.
    always_comb begin
        w_state_next = r_state;
        w_cpu_grant  = 1'b0;
        w_vga_grant  = 1'b0;
        w_cpu_stall  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_stop) begin
                    w_state_next = ST_HALT;
                end
                if ((r_starve_cnt == LIMIT) && i_vga_req) begin
                    w_vga_grant = 1'b1;
                end else if (i_cpu_req) begin
                    w_cpu_grant = 1'b1;
                end else begin
                    w_vga_grant = i_vga_req;
                end
                w_cpu_stall = i_cpu_req & ~w_cpu_grant;
            end
            ST_HALT: begin
                w_vga_grant = i_vga_req;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        w_starve_next = r_starve_cnt;
        if ((r_state == ST_HALT) || w_vga_grant || !i_vga_req) begin
            w_starve_next = 8'd0;
        end else if (w_cpu_grant && (r_starve_cnt != LIMIT)) begin
            w_starve_next = r_starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= 8'd0;
            r_cpu_rd     <= 1'b0;
            r_vga_rd     <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vga_rdata  <= '0;
        end else begin
            r_starve_cnt <= w_starve_next;
            r_cpu_rd     <= w_cpu_grant & ~i_cpu_we;
            r_vga_rd     <= w_vga_grant;
            if (r_cpu_rd) begin
                r_cpu_rdata <= i_mem_rdata;
            end
            if (r_vga_rd) begin
                r_vga_rdata <= i_mem_rdata;
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign o_cpu_stall  = i_rst_n & w_cpu_stall;
    assign o_vga_gnt    = i_rst_n & w_vga_grant;
    assign o_mem_en     = i_rst_n & (w_cpu_grant | w_vga_grant);
    assign o_mem_we     = i_rst_n & w_cpu_grant & i_cpu_we;
    assign o_mem_addr   = w_cpu_grant ? i_cpu_addr  : (w_vga_grant ? i_vga_addr : '0);
    assign o_mem_wdata  = w_cpu_grant ? i_cpu_wdata : '0;

    // Read data passes through in its valid cycle and is held afterwards.
    assign o_cpu_rvalid = r_cpu_rd;
    assign o_vga_rvalid = r_vga_rd;
    assign o_cpu_rdata  = r_cpu_rd ? i_mem_rdata : r_cpu_rdata;
    assign o_vga_rdata  = r_vga_rd ? i_mem_rdata : r_vga_rdata;
    assign o_halted     = (r_state == ST_HALT);

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_cpu_gnt;
    logic [15:0] r_stat_vga_gnt;
    logic [15:0] r_stat_cpu_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_cpu_gnt   <= 16'd0;
            r_stat_vga_gnt   <= 16'd0;
            r_stat_cpu_stall <= 16'd0;
        end else begin
            if (w_cpu_grant && (r_stat_cpu_gnt != 16'hFFFF)) begin
                r_stat_cpu_gnt <= r_stat_cpu_gnt + 16'd1;
            end
            if (w_vga_grant && (r_stat_vga_gnt != 16'hFFFF)) begin
                r_stat_vga_gnt <= r_stat_vga_gnt + 16'd1;
            end
            if (w_cpu_stall && (r_stat_cpu_stall != 16'hFFFF)) begin
                r_stat_cpu_stall <= r_stat_cpu_stall + 16'd1;
            end
        end
    end

    assign o_stat_cpu_gnt   = r_stat_cpu_gnt;
    assign o_stat_vga_gnt   = r_stat_vga_gnt;
    assign o_stat_cpu_stall = r_stat_cpu_stall;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model with its own shadow of the RAM contents.
module tb_dmem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stop = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          cpu_stall, cpu_rvalid, vga_gnt, vga_rvalid;
    logic [DW-1:0] cpu_rdata, vga_rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, halted;
    logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_cpu_gnt, stat_vga_gnt, stat_cpu_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stop(stop),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_vga_req(vga_req), .i_vga_addr(vga_addr), .o_vga_gnt(vga_gnt),
        .o_vga_rvalid(vga_rvalid), .o_vga_rdata(vga_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_halted(halted)
`ifdef ARB_STATS_EN
        , .o_stat_cpu_gnt(stat_cpu_gnt), .o_stat_vga_gnt(stat_vga_gnt),
        .o_stat_cpu_stall(stat_cpu_stall)
`endif
    );

    function automatic logic [DW-1:0] init_pat(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h3C, 8'h5A};
    endfunction

    // Synchronous RAM environment: 256 words, aliased on the low address byte.
    logic [DW-1:0] ram [0:255];
    bit            ram_v [0:255];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]]   <= mem_wdata;
                ram_v[mem_addr[7:0]] <= 1'b1;
            end else begin
                ram_q <= ram_v[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_pat(mem_addr[7:0]);
            end
        end
    end
    assign mem_rdata = ram_q;

    // Reference model state.
    logic [DW-1:0] shadow [0:255];
    bit            m_halted;
    int            m_cnt;
    bit            m_cpu_v, m_vga_v;
    logic [DW-1:0] m_cpu_d, m_vga_d;
    int            m_sc, m_sv, m_ss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_cnt = 0; m_cpu_v = 0; m_vga_v = 0;
        m_cpu_d = '0; m_vga_d = '0; m_sc = 0; m_sv = 0; m_ss = 0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0; stop = 1'b0; cpu_we = 1'b0; cpu_req = 1'b1; vga_req = 1'b1;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vga_rdata", vga_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0; vga_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        $display("reset applied and released at %0t", $time);
    endtask

    task automatic step(input bit s, input bit cr, input bit cw, input logic [15:0] ca,
                        input logic [31:0] cd, input bit vr, input logic [15:0] va);
        bit cg, vg, stall;
        logic [15:0] ea;
        logic [31:0] ed;
        @(negedge clk);
        stop = s; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        vga_req = vr; vga_addr = va;
        #1;
        cg = 0; vg = 0;
        if (m_halted) vg = vr;
        else if (m_cnt == LIMIT && vr) vg = 1;
        else if (cr) cg = 1;
        else vg = vr;
        stall = !m_halted && cr && !cg;
        ea = cg ? ca : (vg ? va : 16'h0);
        ed = cg ? cd : 32'h0;
        chk("vga_gnt", vga_gnt, vg);
        chk("cpu_stall", cpu_stall, stall);
        chk("mem_en", mem_en, cg | vg);
        chk("mem_we", mem_we, cg & cw);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        $display("t=%0t stop=%0b cpu_req=%0b we=%0b vga_req=%0b -> cpu_gnt=%0b vga_gnt=%0b stall=%0b addr=%h",
                 $time, s, cr, cw, vr, cg, vg, stall, ea);
        @(posedge clk);
        #1;
        m_cpu_v = cg && !cw;
        m_vga_v = vg;
        if (m_cpu_v) m_cpu_d = shadow[ca[7:0]];
        if (vg) m_vga_d = shadow[va[7:0]];
        if (cg && cw) shadow[ca[7:0]] = cd;
        if (m_halted || vg || !vr) m_cnt = 0;
        else if (cg && m_cnt < LIMIT) m_cnt = m_cnt + 1;
        if (cg && m_sc < 65535) m_sc++;
        if (vg && m_sv < 65535) m_sv++;
        if (stall && m_ss < 65535) m_ss++;
        if (s) m_halted = 1;
        chk("halted", halted, m_halted);
        chk("cpu_rvalid", cpu_rvalid, m_cpu_v);
        chk("vga_rvalid", vga_rvalid, m_vga_v);
        chk("cpu_rdata", cpu_rdata, m_cpu_d);
        chk("vga_rdata", vga_rdata, m_vga_d);
`ifdef ARB_STATS_EN
        chk("stat_cpu_gnt", stat_cpu_gnt, m_sc);
        chk("stat_vga_gnt", stat_vga_gnt, m_sv);
        chk("stat_cpu_stall", stat_cpu_stall, m_ss);
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_pat(8'(i));
        model_reset();
        do_reset();

        // First cycle after reset: CPU wins against VGA.
        step(0, 1, 0, 16'h0004, 32'h0, 1, 16'h0100);
        // CPU load of 0x0010.
        step(0, 1, 0, 16'h0010, 32'h0, 0, 16'h0);
        chk("load_data", cpu_rdata, 32'hDEADBEEF);
        // CPU store to 0x0020, then read it back.
        step(0, 1, 1, 16'h0020, 32'h00000055, 0, 16'h0);
        step(0, 1, 0, 16'h0020, 32'h0, 0, 16'h0);
        chk("store_readback", cpu_rdata, 32'h00000055);

        // Contention with both requests held high: period LIMIT+1.
        do_reset();
        for (int i = 0; i < 18; i++) step(0, 1, 0, 16'(i), 32'h0, 1, 16'(16'h0200 + i));
`ifdef ARB_STATS_EN
        chk("stats_cpu_18", stat_cpu_gnt, 16);
        chk("stats_vga_18", stat_vga_gnt, 2);
        chk("stats_stall_18", stat_cpu_stall, 2);
`endif

        // Halt with a CPU read in flight, then drop stop.
        step(1, 1, 0, 16'h0010, 32'h0, 0, 16'h0);
        chk("halt_inflight_rvalid", cpu_rvalid, 1);
        chk("halt_halted", halted, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 16'h0030, 32'h1234, 1, 16'(16'h0300 + i));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0031, 32'h0, 1, 16'(16'h0310 + i));
        chk("halt_sticky", halted, 1);

        // Reset while a read is pending: nothing returns afterwards.
        do_reset();
        step(0, 1, 0, 16'h0040, 32'h0, 0, 16'h0);
        do_reset();
        step(0, 0, 0, 16'h0, 32'h0, 0, 16'h0);

        // Randomized traffic in RUN, then with occasional stop.
        for (int i = 0; i < 400; i++)
            step(0, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, 16'($urandom),
                 $urandom, $urandom_range(0, 9) < 7, 16'($urandom));
        do_reset();
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 16'($urandom), $urandom, $urandom_range(0, 3) != 0, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Single-port data-memory arbiter between the CPU load/store path (LDR/STR) and the VGA frame reader.
- While the core runs, the CPU has priority, with a starvation bound that guarantees VGA progress.
- Once the control unit raises stop (END decoded), the arbiter latches a halted state and gives the memory port exclusively to VGA readout.
- Sits between the pipeline memory stage, the VGA controller and the synchronous data RAM.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, data width
STARVE_LIMIT, 8, max consecutive CPU grants while VGA is waiting (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stop  in  1  halt request from control unit
cpu_req  in  1  CPU access request (LDR or STR)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  store data
cpu_stall  out  1  CPU request not granted this cycle
cpu_rvalid  out  1  load data valid
cpu_rdata  out  DATA_W  load data
vga_req  in  1  VGA read request
vga_addr  in  ADDR_W  VGA read address
vga_gnt  out  1  VGA request granted this cycle
vga_rvalid  out  1  VGA read data valid
vga_rdata  out  DATA_W  VGA read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read issue
halted  out  1  arbiter is in the HALT state

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = RUN, starve_cnt = 0.
  - cpu_rvalid = vga_rvalid = 0; cpu_rdata = vga_rdata = 0; halted = 0.
  - While rst_n = 0, mem_en, mem_we, vga_gnt and cpu_stall are forced to 0.
- States:
  - RUN -> HALT when stop = 1 at a clock edge.
  - HALT is sticky until reset; deasserting stop has no effect.
  - halted = (state == HALT), registered.
- Grant is combinational, at most one access per cycle:
  - RUN, starve_cnt == STARVE_LIMIT and vga_req = 1: VGA wins.
  - RUN otherwise: CPU wins if cpu_req = 1, else VGA wins if vga_req = 1.
  - HALT: VGA wins whenever vga_req = 1. cpu_req is ignored and cpu_stall = 0.
- The stop-cycle grant still follows RUN rules; HALT takes effect from the next cycle.
- Signal definitions:
  - cpu_stall = cpu_req & ~cpu_grant (RUN only).
  - vga_gnt = vga_grant.
- Memory port (combinational from the winner):
  - mem_en = any grant.
  - mem_we = cpu_grant & cpu_we. VGA never writes.
  - mem_addr and mem_wdata are muxed from the winner; 0 when idle.
- Stores complete at the grant edge and produce no rvalid.
- Read latency: 1 cycle.
  - A registered tag {cpu_rd, vga_rd} captures the read grant.
  - Next cycle the matching rvalid = 1 and its rdata is registered from mem_rdata. The other side's rvalid = 0 and its rdata holds its last value.
- starve_cnt, 8-bit register, updated at each edge:
  - Cleared if vga_grant or vga_req = 0.
  - Incremented (saturating at STARVE_LIMIT) if cpu_grant & vga_req.
  - Held at 0 in HALT.
- In-flight read at stop: a CPU read granted in the stop cycle still returns cpu_rvalid the following cycle.
- Reset mid-access: the pending tag is discarded and no rvalid is emitted after rst_n rises.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds three 16-bit saturating counters, cleared by reset: stat_cpu_gnt, stat_vga_gnt, stat_cpu_stall.
  - Each increments once per cycle of a CPU grant, a VGA grant, or cpu_stall = 1 respectively.
  - Each is exposed as an output port of the same name; saturation holds at 0xFFFF.
- When undefined: the counters and their ports are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with cpu_req = vga_req = 1 -> mem_en = 0, vga_gnt = 0, cpu_stall = 0, all rvalids 0. Release -> CPU granted the first cycle, halted = 0.
- CPU load: cpu_req = 1, cpu_we = 0, cpu_addr = 0x0010, RAM returns 0xDEADBEEF -> mem_en = 1 and mem_addr = 0x0010 in cycle N; cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF in N+1; cpu_stall = 0 throughout.
- CPU store: cpu_we = 1, addr 0x0020, data 0x00000055 -> mem_we = 1, mem_wdata = 0x55 the same cycle; no rvalid the next cycle.
- Contention, STARVE_LIMIT = 8, cpu_req and vga_req held high -> CPU granted cycles 1-8, VGA granted cycle 9 with cpu_stall = 1, then the pattern repeats with period 9.
- Halt: CPU read granted at cycle N with stop = 1 -> cpu_rvalid = 1 at N+1, halted = 1 from N+1, vga_gnt = 1 every cycle from N+1. Dropping stop at N+5 -> halted stays 1.
- Stats (ARB_STATS_EN): run the contention scenario for 18 cycles -> stat_cpu_gnt = 16, stat_vga_gnt = 2, stat_cpu_stall = 2.
